// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit with an internal synchronous-read data RAM and
// one memory-mapped display register. Accepts at most one request at a time
// and answers with a single-cycle response pulse two cycles after acceptance.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req_valid/ready request handshake; accept = req_valid && req_ready
//   req_we          1 = store, 0 = load
//   req_funct3      RV32I funct3 of the load/store
//   req_addr        byte address
//   req_wdata       store data (low byte/half used for sb/sh)
//   rsp_valid       one-cycle response pulse
//   rsp_rdata       aligned, extended load data (0 for stores and faults)
//   rsp_fault       request rejected, no architectural effect
//   disp_data       display register, written by sw to MMIO_ADDR
module riscv_lsu #(
    parameter int          WORDS_LOG2 = 10,
    parameter logic [31:0] MMIO_ADDR  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] disp_data
);
    localparam int WORDS = 1 << WORDS_LOG2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;
    logic   accept;

    // request captured at the accepting edge
    logic        we_p0;
    logic [2:0]  f3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic [31:0] mem [WORDS];
    logic [31:0] ram_q_p1;

    logic                  is_mmio, fault;
    logic [1:0]            lane;
    logic [WORDS_LOG2-1:0] idx;
    logic [3:0]            be;
    logic [31:0]           wdata_sh;
    logic                  commit, ram_we, disp_we;
    logic [31:0]           rsp_live;
    logic [31:0]           rdata_hold;
    logic                  fault_hold;

    // Align the addressed lane to bit 0 and extend as the load type demands.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  ln);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {ln, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'd0:    return 32'(b);
            3'd1:    return 32'(h);
            3'd2:    return sh;
            3'd4:    return {24'b0, sh[7:0]};
            3'd5:    return {16'b0, sh[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ACCESS;
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                state_nxt = req_valid ? ACCESS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            f3_p0    <= req_funct3;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // Decode of the captured request; fields stay stable through ACCESS and RESP.
    always_comb begin
        logic reserved, mis_half, mis_word, oob, mmio_bad;
        is_mmio  = (addr_p0 == MMIO_ADDR);
        reserved = we_p0 ? (f3_p0[2] || f3_p0[1:0] == 2'd3)
                         : (f3_p0 == 3'd3 || f3_p0 == 3'd6 || f3_p0 == 3'd7);
        mis_half = (f3_p0[1:0] == 2'd1) && addr_p0[0];
        mis_word = (f3_p0[1:0] == 2'd2) && (addr_p0[1:0] != 2'd0);
        oob      = !is_mmio && (addr_p0[31:WORDS_LOG2+2] != '0);
        mmio_bad = is_mmio && (f3_p0 != 3'd2);
        fault    = reserved || mis_half || mis_word || oob || mmio_bad;
        lane     = addr_p0[1:0];
        idx      = addr_p0[WORDS_LOG2+1:2];
        case (f3_p0[1:0])
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        wdata_sh = wdata_p0 << {lane, 3'b000};
    end

    // rst at the edge ending ACCESS suppresses every write
    assign commit  = (state == ACCESS) && !rst && !fault && we_p0;
    assign ram_we  = commit && !is_mmio;
    assign disp_we = commit && is_mmio;

    // ACCESS -> RESP boundary: RAM write commit and synchronous read
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we && be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
            ram_q_p1 <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          disp_data <= 32'b0;
        else if (disp_we) disp_data <= wdata_p0;
    end

    always_comb begin
        if (fault || we_p0) rsp_live = 32'b0;
        else if (is_mmio)   rsp_live = disp_data;
        else                rsp_live = load_extend(ram_q_p1, f3_p0, lane);
    end

    // RESP -> next boundary: keep the last response visible after the pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold <= 32'b0;
            fault_hold <= 1'b0;
        end else if (state == RESP) begin
            rdata_hold <= rsp_live;
            fault_hold <= fault;
        end
    end

    assign rsp_rdata = rsp_valid ? rsp_live : rdata_hold;
    assign rsp_fault = rsp_valid ? fault    : fault_hold;

endmodule
